// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver oversampled in clk_cpu, with a scancode FIFO and error pulses.
// Latency: stop-bit sample event to valid = 1 cycle; error pulses follow their cause by 1 cycle.
// Backpressure: head byte held while ready=0; a byte arriving at a full FIFO with no pop is dropped (overflow).
// Optional build macro PS2_ERR_CNT_EN adds the saturating err_cnt output.

// First-word fall-through byte buffer; accepts a push while full only if a pop happens in the same cycle.
module ps2_rx_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dat,
  output logic                     o_vld,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_full    = (r_count == FULL_CNT);
  assign o_vld     = (r_count != '0);
  assign w_do_pop  = i_pop & o_vld;
  // When full, the slot being written is the head being popped, so the overwrite is safe.
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;
  assign o_count   = r_count;
  // Head is forced to zero while empty so the output is clean out of reset.
  assign o_dat     = o_vld ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                          clk_cpu,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    scancode,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
`ifdef PS2_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]          err_cnt
`endif
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s;
  logic                   w_dat;
  logic [FW-1:0]          r_flt_cnt;
  logic                   r_flt_clk;
  logic                   r_flt_d;
  logic                   w_se;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic                   r_ok;
  logic [TW-1:0]          r_tmo_cnt;
  logic                   w_tmo;
  logic                   w_push;
  logic                   w_perr;
  logic                   w_ferr;
  logic                   w_drop;

  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_overflow;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat   = r_dat_sync[SYNC_STAGES-1];

  // Synchronise both raw lines; idle-high bus means reset to ones.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_flt_cnt <= '0;
      r_flt_clk <= 1'b1;
      r_flt_d   <= 1'b1;
    end else begin
      r_flt_d <= r_flt_clk;
      if (w_clk_s == r_flt_clk) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_flt_clk <= w_clk_s;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  // Sample event: one cycle on each filtered 1->0 transition.
  assign w_se = r_flt_d & ~r_flt_clk;

  // Inter-edge watchdog; a sample event always wins over a coincident expiry.
  assign w_tmo = (r_state != S_IDLE) & ~w_se & (r_tmo_cnt == TMO_LAST);

  // Frame FSM state register.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next state and per-frame verdicts.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_perr      = 1'b0;
    w_ferr      = 1'b0;
    if (w_tmo) begin
      w_state_nxt = S_IDLE;
      w_ferr      = 1'b1;
    end else if (w_se) begin
      case (r_state)
        S_IDLE: begin
          if (!w_dat) begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (!w_dat) begin
            w_ferr = 1'b1;
          end else if (!r_ok) begin
            w_perr = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Shift register, bit index and parity verdict, advanced on sample events.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_ok      <= 1'b0;
    end else if (w_tmo) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_ok      <= 1'b0;
    end else if (w_se) begin
      case (r_state)
        S_IDLE: begin
          r_bit_idx <= '0;
        end
        S_DATA: begin
          r_shift[r_bit_idx] <= w_dat;
          r_bit_idx          <= r_bit_idx + 1'b1;
        end
        S_PARITY: begin
          // Odd parity: the parity bit together with the data holds an odd number of ones.
          r_ok <= w_dat ^ (^r_shift);
        end
        default: begin
          r_bit_idx <= r_bit_idx;
        end
      endcase
    end
  end

  // Timeout counter: idle-cleared, restarted on every sample event.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_se || w_tmo) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  ps2_rx_fifo_buf #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk_cpu),
    .i_rst_n    (rst_n),
    .i_push     (w_push),
    .i_push_dat (r_shift),
    .i_pop      (ready),
    .o_dat      (scancode),
    .o_vld      (valid),
    .o_count    (fifo_count),
    .o_drop     (w_drop)
  );

  // Error pulses, registered one cycle after their cause.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
      r_frame_err  <= w_ferr;
      r_overflow   <= w_drop;
    end
  end

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

`ifdef PS2_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating error counter, one step per cycle with any error pulse.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if ((r_parity_err | r_frame_err | r_overflow) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_w;
  assign w_unused_err_w = (ERR_CNT_W != 0);
`endif
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: drives PS/2 frames into ps2_rx_fifo and scoreboards the popped scancodes.
// Latency: checks stop-bit fall to valid timing for one frame.
// Backpressure: exercises ready=0 fill, overflow drop and drain.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_cpu  = 1'b0;
  logic          rst_n    = 1'b0;
  logic          ps2_clk  = 1'b1;
  logic          ps2_data = 1'b1;
  logic          ready    = 1'b0;
  logic [7:0]    scancode;
  logic          valid;
  logic [CW-1:0] fifo_count;
  logic          parity_err;
  logic          frame_err;
  logic          overflow;
`ifdef PS2_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_perr = 0, n_ferr = 0, n_ovf = 0;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  logic [7:0] q [$];

  ps2_rx_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2),
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TMO),
    .ERR_CNT_W   (8)
  ) dut (
    .clk_cpu    (clk_cpu),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scancode   (scancode),
    .valid      (valid),
    .ready      (ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
`ifdef PS2_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_perr"}, n_perr, exp_perr);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_ovf"},  n_ovf,  exp_ovf);
  endtask

  // Count error pulse cycles.
  always @(negedge clk_cpu) begin
    if (parity_err === 1'b1) n_perr++;
    if (frame_err  === 1'b1) n_ferr++;
    if (overflow   === 1'b1) n_ovf++;
  end

  // Scoreboard: every accepted pop must match the oldest expected byte.
  always @(negedge clk_cpu) begin
    if (rst_n && valid && ready) begin
      if (q.size() == 0) begin
        check("sb_unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        check("sb_byte", {24'd0, scancode}, {24'd0, q.pop_front()});
      end
    end
  end

  // Advance n cycles and land just after the rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_cpu);
    #2;
  endtask

  task automatic ps2_bit(input logic b, input logic g);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    if (g) begin
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end else begin
      wait_cyc(10);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input logic g);
    ps2_bit(1'b0, g);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], g);
    ps2_bit(par, g);
    ps2_bit(stp, g);
    ps2_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] d, input logic g);
    if (!ready && q.size() >= DEPTH) exp_ovf++;
    else q.push_back(d);
    send_frame(d, ~^d, 1'b1, g);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int lat;
    logic seen;

    // Reset state
    wait_cyc(3);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_count", {28'd0, fifo_count}, 32'd0);
    check("rst_scancode", {24'd0, scancode}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good 0x1C with latency measurement on the stop bit
    ready = 1'b1;
    d = 8'h1C;
    q.push_back(d);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(10);
    ps2_clk = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk_cpu);
      @(negedge clk_cpu);
      lat++;
      if (valid) seen = 1'b1;
    end
    // 2 sync edges + 4 filter samples to the sample event, then 1 cycle to valid
    check("t1_latency", lat, 7);
    @(negedge clk_cpu);
    check("t1_valid_after_pop", {31'd0, valid}, 32'd0);
    check("t1_count_after_pop", {28'd0, fifo_count}, 32'd0);
    wait_cyc(15);
    ps2_clk = 1'b1;
    wait_cyc(10);
    check_errs("t1");
    check("t1_q_empty", q.size(), 0);

    // Bad parity on 0xF0
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    exp_perr++;
    wait_cyc(5);
    check_errs("t2");
    check("t2_valid", {31'd0, valid}, 32'd0);
`ifdef PS2_ERR_CNT_EN
    check("t2_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif

    // Stop bit 0
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    exp_ferr++;
    wait_cyc(5);
    check_errs("t3");
    check("t3_count", {28'd0, fifo_count}, 32'd0);

    // Timeout mid-frame, then a good 0x29
    d = 8'h29;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(d[i], 1'b0);
    wait_cyc(TMO + 100);
    exp_ferr++;
    check_errs("t4_tmo");
    check("t4_count", {28'd0, fifo_count}, 32'd0);
    good(8'h29, 1'b0);
    wait_cyc(5);
    check_errs("t4");
    check("t4_q_empty", q.size(), 0);

    // Fill with ready=0, overflow on the 9th, then drain
    ready = 1'b0;
    for (int i = 1; i <= 8; i++) good(8'(i), 1'b0);
    wait_cyc(5);
    check("t5_count_full", {28'd0, fifo_count}, 32'd8);
    check("t5_valid", {31'd0, valid}, 32'd1);
    check("t5_head", {24'd0, scancode}, 32'h01);
    good(8'h09, 1'b0);
    wait_cyc(5);
    check("t5_count_ovf", {28'd0, fifo_count}, 32'd8);
    check_errs("t5_ovf");
    ready = 1'b1;
    wait_cyc(20);
    check("t5_count_drained", {28'd0, fifo_count}, 32'd0);
    check("t5_q_empty", q.size(), 0);

    // Clock glitches in IDLE and during the frame
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(20);
    good(8'h3A, 1'b1);
    wait_cyc(5);
    check_errs("t6");
    check("t6_q_empty", q.size(), 0);
    check("t6_valid", {31'd0, valid}, 32'd0);

`ifdef PS2_ERR_CNT_EN
    check("t6_err_cnt", {24'd0, err_cnt}, 32'(exp_perr + exp_ferr + exp_ovf));
`endif

    // Reset mid-FIFO and mid-frame
    ready = 1'b0;
    good(8'h11, 1'b0);
    good(8'h22, 1'b0);
    wait_cyc(5);
    check("t7_count_pre", {28'd0, fifo_count}, 32'd2);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t7_rst_count", {28'd0, fifo_count}, 32'd0);
    check("t7_rst_valid", {31'd0, valid}, 32'd0);
    check("t7_rst_scancode", {24'd0, scancode}, 32'd0);
`ifdef PS2_ERR_CNT_EN
    check("t7_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    q.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    ready = 1'b1;
    wait_cyc(5);
    good(8'h5A, 1'b0);
    wait_cyc(10);
    check("t7_q_empty", q.size(), 0);
    check("t7_count", {28'd0, fifo_count}, 32'd0);
    check_errs("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
